// File: rtl/rv_int_pipe.sv
// rv_int_pipe -- three-stage in-order RV32I/RV64I integer pipeline.
//
// Stages:
//   S1  decode and operand read (register file and, optionally, bypass)
//   S2  holds operands and ALU opcode; ALU result is combinational
//   S3  registered result drives the writeback outputs; the register file
//       is written on the edge that ends S3
//
// Supported: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND,
//            ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI, LUI.
// Anything else, or a used register index >= NREGS, is illegal.
//
// Compile-time option:
//   RV_FWD_EN  defined   -> S1 operands bypass from the S2 ALU output
//                           (priority) or the S3 result; never stalls.
//              undefined -> RAW hazards against S2/S3 interlock S1.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   NREGS  architectural registers, 16 or 32
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr_valid     an instruction is offered
//   instr           instruction word
//   instr_ready     pipeline accepts instr this cycle
//   wb_valid        a legal result is in writeback this cycle
//   wb_rd, wb_data  writeback register index and value
//   flags           {Z,N,C,V} of the most recent legal instruction
//   illegal         one-cycle pulse when an illegal instruction is in S3
//   dbg_raddr       debug register-file read address
//   dbg_rdata       combinational register-file read (not bypassed)
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready depends only on rst and on the
// S1/S2/S3 state, never on instr_valid. There is no output backpressure.

module rv_int_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [3:0]      flags,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int unsigned SHW    = $clog2(XLEN);
    localparam int unsigned RW     = $clog2(NREGS);
    localparam logic [5:0]  NREGS6 = 6'(NREGS);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } alu_op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_instr_q, s1_instr_d;

    logic            s2_valid_q, s2_valid_d;
    logic            s2_legal_q, s2_legal_d;
    alu_op_e         s2_op_q,    s2_op_d;
    logic [4:0]      s2_rd_q,    s2_rd_d;
    logic [XLEN-1:0] s2_a_q,     s2_a_d;
    logic [XLEN-1:0] s2_b_q,     s2_b_d;

    logic            s3_valid_q,   s3_valid_d;
    logic            s3_illegal_q, s3_illegal_d;
    logic [4:0]      s3_rd_q,      s3_rd_d;
    logic [XLEN-1:0] s3_data_q,    s3_data_d;

    logic [3:0]      flags_q, flags_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Register-file read; x0 and out-of-range indices read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || {1'b0, idx} >= NREGS6) begin
            return '0;
        end
        return regs_q[idx[RW-1:0]];
    endfunction

    // ------------------------------------------------------------------
    // S1 decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    logic [4:0] rd, rs1, rs2;
    logic       dec_legal, uses_rs1, uses_rs2, use_imm, shamt_ok;
    alu_op_e    dec_op;
    logic [XLEN-1:0] i_imm, lui_imm;

    assign opcode = s1_instr_q[6:0];
    assign rd     = s1_instr_q[11:7];
    assign f3     = s1_instr_q[14:12];
    assign rs1    = s1_instr_q[19:15];
    assign rs2    = s1_instr_q[24:20];
    assign f7     = s1_instr_q[31:25];
    assign f6     = s1_instr_q[31:26];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        use_imm   = 1'b0;
        // On RV32 instr[25] would be shamt bit 5, which does not exist.
        shamt_ok  = (XLEN == 64) || !s1_instr_q[25];

        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ZERO) begin
                            dec_legal = 1'b1; dec_op = ALU_ADD;
                        end else if (f7 == F7_ALT) begin
                            dec_legal = 1'b1; dec_op = ALU_SUB;
                        end
                    end
                    3'b001: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_SLL;  end
                    3'b010: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_SLT;  end
                    3'b011: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_SLTU; end
                    3'b100: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_XOR;  end
                    3'b101: begin
                        if (f7 == F7_ZERO) begin
                            dec_legal = 1'b1; dec_op = ALU_SRL;
                        end else if (f7 == F7_ALT) begin
                            dec_legal = 1'b1; dec_op = ALU_SRA;
                        end
                    end
                    3'b110: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_OR;   end
                    default: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_AND; end
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                use_imm  = 1'b1;
                case (f3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_op = ALU_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_op = ALU_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND;  end
                    3'b001: begin
                        dec_legal = (f6 == 6'b000000) && shamt_ok;
                        dec_op    = ALU_SLL;
                    end
                    default: begin
                        if (f6 == 6'b000000) begin
                            dec_legal = shamt_ok; dec_op = ALU_SRL;
                        end else if (f6 == 6'b010000) begin
                            dec_legal = shamt_ok; dec_op = ALU_SRA;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_op    = ALU_LUI;
            end
            default: ;
        endcase

        // RV-E: any referenced register beyond the file is illegal.
        if ({1'b0, rd} >= NREGS6 ||
            (uses_rs1 && {1'b0, rs1} >= NREGS6) ||
            (uses_rs2 && {1'b0, rs2} >= NREGS6)) begin
            dec_legal = 1'b0;
        end

        i_imm         = {XLEN{s1_instr_q[31]}};
        i_imm[11:0]   = s1_instr_q[31:20];
        lui_imm       = {XLEN{s1_instr_q[31]}};
        lui_imm[31:0] = {s1_instr_q[31:12], 12'h000};
    end

    // ------------------------------------------------------------------
    // S2 ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v;
    logic [XLEN:0]   sum_add, sum_sub;
    logic [SHW-1:0]  shamt;

    assign shamt   = s2_b_q[SHW-1:0];
    assign sum_add = {1'b0, s2_a_q} + {1'b0, s2_b_q};
    assign sum_sub = {1'b0, s2_a_q} + {1'b0, ~s2_b_q} + {{XLEN{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s2_op_q)
            ALU_ADD: begin
                alu_res = sum_add[XLEN-1:0];
                alu_c   = sum_add[XLEN];
                alu_v   = (s2_a_q[XLEN-1] == s2_b_q[XLEN-1]) &&
                          (alu_res[XLEN-1] != s2_a_q[XLEN-1]);
            end
            ALU_SUB: begin
                // Carry here is "no borrow".
                alu_res = sum_sub[XLEN-1:0];
                alu_c   = sum_sub[XLEN];
                alu_v   = (s2_a_q[XLEN-1] != s2_b_q[XLEN-1]) &&
                          (alu_res[XLEN-1] != s2_a_q[XLEN-1]);
            end
            ALU_SLL:  alu_res = s2_a_q << shamt;
            ALU_SLT:  alu_res[0] = $signed(s2_a_q) < $signed(s2_b_q);
            ALU_SLTU: alu_res[0] = s2_a_q < s2_b_q;
            ALU_XOR:  alu_res = s2_a_q ^ s2_b_q;
            ALU_SRL:  alu_res = s2_a_q >> shamt;
            ALU_SRA:  alu_res = $signed(s2_a_q) >>> shamt;
            ALU_OR:   alu_res = s2_a_q | s2_b_q;
            ALU_AND:  alu_res = s2_a_q & s2_b_q;
            default:  alu_res = s2_b_q;   // LUI: immediate arrives on b
        endcase
    end

    // ------------------------------------------------------------------
    // S1 operand selection and hazard handling
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            stall;

`ifdef RV_FWD_EN
    logic s2_src, s3_src;
    assign s2_src = s2_valid_q && s2_legal_q && (s2_rd_q != 5'd0);
    assign s3_src = s3_valid_q && !s3_illegal_q && (s3_rd_q != 5'd0);

    always_comb begin
        rs1_val = rf_read(rs1);
        rs2_val = rf_read(rs2);
        // S3 first, then S2 overrides: the younger result wins.
        if (s3_src && s3_rd_q == rs1) rs1_val = s3_data_q;
        if (s3_src && s3_rd_q == rs2) rs2_val = s3_data_q;
        if (s2_src && s2_rd_q == rs1) rs1_val = alu_res;
        if (s2_src && s2_rd_q == rs2) rs2_val = alu_res;
    end

    assign stall = 1'b0;
`else
    logic s2_dst, s3_dst, rs1_hit, rs2_hit;
    assign s2_dst  = s2_valid_q && (s2_rd_q != 5'd0);
    assign s3_dst  = s3_valid_q && (s3_rd_q != 5'd0);
    assign rs1_hit = uses_rs1 && ((s2_dst && s2_rd_q == rs1) ||
                                  (s3_dst && s3_rd_q == rs1));
    assign rs2_hit = uses_rs2 && ((s2_dst && s2_rd_q == rs2) ||
                                  (s3_dst && s3_rd_q == rs2));

    always_comb begin
        rs1_val = rf_read(rs1);
        rs2_val = rf_read(rs2);
    end

    assign stall = s1_valid_q && dec_legal && (rs1_hit || rs2_hit);
`endif

    assign instr_ready = !rst && !stall;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        // S1: hold while interlocked, otherwise take the offered word.
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        if (!stall) begin
            s1_valid_d = instr_valid && instr_ready;
            if (instr_valid && instr_ready) s1_instr_d = instr;
        end

        // S2: a stall inserts a bubble.
        s2_valid_d = s1_valid_q && !stall;
        s2_legal_d = dec_legal;
        s2_op_d    = dec_op;
        s2_rd_d    = rd;
        s2_a_d     = (dec_op == ALU_LUI) ? '0 : rs1_val;
        s2_b_d     = (dec_op == ALU_LUI) ? lui_imm :
                     use_imm             ? i_imm   : rs2_val;

        // S3: illegal entries carry no destination or data.
        s3_valid_d   = s2_valid_q;
        s3_illegal_d = !s2_legal_q;
        s3_rd_d      = (s2_valid_q && s2_legal_q) ? s2_rd_q : 5'd0;
        s3_data_d    = (s2_valid_q && s2_legal_q) ? alu_res : '0;

        flags_d = flags_q;
        if (s2_valid_q && s2_legal_q) begin
            flags_d = {(alu_res == '0), alu_res[XLEN-1], alu_c, alu_v};
        end

        regs_d = regs_q;
        if (s3_valid_q && !s3_illegal_q && s3_rd_q != 5'd0) begin
            regs_d[s3_rd_q[RW-1:0]] = s3_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_instr_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_legal_q   <= 1'b0;
            s2_op_q      <= ALU_ADD;
            s2_rd_q      <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s3_valid_q   <= 1'b0;
            s3_illegal_q <= 1'b0;
            s3_rd_q      <= '0;
            s3_data_q    <= '0;
            flags_q      <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_instr_q   <= s1_instr_d;
            s2_valid_q   <= s2_valid_d;
            s2_legal_q   <= s2_legal_d;
            s2_op_q      <= s2_op_d;
            s2_rd_q      <= s2_rd_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s3_valid_q   <= s3_valid_d;
            s3_illegal_q <= s3_illegal_d;
            s3_rd_q      <= s3_rd_d;
            s3_data_q    <= s3_data_d;
            flags_q      <= flags_d;
            regs_q       <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_valid  = s3_valid_q && !s3_illegal_q;
    assign illegal   = s3_valid_q && s3_illegal_q;
    assign wb_rd     = s3_rd_q;
    assign wb_data   = s3_data_q;
    assign flags     = flags_q;
    assign dbg_rdata = rf_read(dbg_raddr);

endmodule
